// File: rtl/uart_tx_word_queue_if.sv
// Producer and UART-side signal bundle for the word queue.
// slave is the queue's view; master is the driver/bench view.
interface uart_tx_word_queue_if #(
  parameter int DATA_W = 128
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              en_tx;
  logic [DATA_W-1:0] data_in;
  logic              u_tx_done;

  modport master (
    output s_valid, s_data, u_tx_done,
    input  s_ready, en_tx, data_in
  );

  modport slave (
    input  s_valid, s_data, u_tx_done,
    output s_ready, en_tx, data_in
  );
endinterface

// File: rtl/uart_tx_word_queue.sv
// Word FIFO feeding a 128-bit UART: launch, await done,
// then hold an idle gap before the next word.
module uart_tx_word_queue #(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int GAP_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_word_queue_if.slave bus,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic [15:0]         words_sent
);
  localparam int GW =
    (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [ADDR_W:0] FULL =
    (ADDR_W + 1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LD =
    GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE_WAIT,
    GAP
  } state_t;

  state_t state;
  state_t state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [GW-1:0]     gap_cnt;
  logic [GW-1:0]     gap_cnt_n;
  logic              push;
  logic              pop;

  // A full queue refuses pushes even when a pop
  // frees a slot on the same edge.
  assign bus.s_ready = count < FULL;
  assign busy        = state != IDLE;
  assign push        = bus.s_valid && bus.s_ready;
  assign pop         = (state == IDLE) && (count != '0);

  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    unique case (state)
      IDLE: begin
        if (pop) state_n = SEND;
      end
      SEND: begin
        if (bus.u_tx_done) state_n = DONE_WAIT;
      end
      DONE_WAIT: begin
        if (!bus.u_tx_done) begin
          state_n   = GAP;
          gap_cnt_n = GAP_LD;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else gap_cnt_n = gap_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      bus.en_tx   <= 1'b0;
      bus.data_in <= '0;
      words_sent  <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_cnt_n;
      bus.en_tx <= (state_n == SEND);
      if (pop) begin
        bus.data_in <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (state == SEND && bus.u_tx_done)
        words_sent <= words_sent + 16'd1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_word_queue.sv
// Directed bench for uart_tx_word_queue with a queue-based
// reference model compared on every falling edge.
module tb_uart_tx_word_queue;
  localparam int DATA_W  = 128;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int GAP_CYC = 2;

  typedef logic [DATA_W-1:0] word_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ADDR_W:0] count;
  logic            busy;
  logic [15:0]     words_sent;

  uart_tx_word_queue_if #(.DATA_W(DATA_W)) bus ();

  uart_tx_word_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .count     (count),
    .busy      (busy),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name,
                     input word_t act,
                     input word_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: queue of pending words, current
  // transmit flag, and the edge from which a launch is
  // allowed again after the idle gap.
  word_t       mq[$];
  bit          m_tx;
  bit          m_wl;
  word_t       m_data;
  int unsigned m_sent;
  longint      ecount;
  longint      m_idle_edge;

  initial begin
    m_tx        = 0;
    m_wl        = 0;
    m_data      = '0;
    m_sent      = 0;
    ecount      = 0;
    m_idle_edge = 0;
  end

  always @(posedge clk) begin
    bit full;
    bit acc;
    bit idle;
    ecount++;
    full = mq.size() >= DEPTH;
    acc  = bus.s_valid && !full;
    if (rst) begin
      mq.delete();
      m_tx        = 0;
      m_wl        = 0;
      m_data      = '0;
      m_sent      = 0;
      m_idle_edge = 0;
    end else begin
      idle = !m_tx && !m_wl && (ecount >= m_idle_edge);
      if (idle && mq.size() > 0) begin
        m_data = mq.pop_front();
        m_tx   = 1;
      end else if (m_tx && bus.u_tx_done) begin
        m_tx = 0;
        m_wl = 1;
        m_sent++;
      end else if (m_wl && !bus.u_tx_done) begin
        m_wl        = 0;
        m_idle_edge = ecount + GAP_CYC + 1;
      end
      if (acc) mq.push_back(bus.s_data);
    end
  end

  bit chk_on = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en_tx", word_t'(bus.en_tx), word_t'(m_tx));
      chk("data_in", bus.data_in, m_data);
      chk("count", word_t'(count), word_t'(mq.size()));
      chk("s_ready", word_t'(bus.s_ready),
          word_t'(mq.size() < DEPTH));
      chk("busy", word_t'(busy),
          word_t'(m_tx || m_wl || (ecount + 1 < m_idle_edge)));
      chk("words_sent", word_t'(words_sent),
          word_t'(16'(m_sent)));
    end
  end

  word_t launched[$];
  logic  prev_en = 1'b0;

  always @(negedge clk) begin
    if (bus.en_tx === 1'b1 && prev_en !== 1'b1)
      launched.push_back(bus.data_in);
    prev_en = bus.en_tx;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input word_t w);
    bit ok;
    ok = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = bus.s_ready;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    if (!ok) fail_now("push");
  endtask

  task automatic serve(input int hold);
    int i;
    i = 0;
    while (bus.en_tx !== 1'b1 && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (i >= 300) fail_now("serve");
    tick(1);
    bus.u_tx_done = 1'b1;
    tick(hold);
    bus.u_tx_done = 1'b0;
  endtask

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.u_tx_done = 1'b0;
    rst           = 1'b1;
    tick(2);
    chk_on = 1;
    chk("rst_count", word_t'(count), word_t'(0));
    chk("rst_en_tx", word_t'(bus.en_tx), word_t'(0));
    chk("rst_data", bus.data_in, word_t'(0));
    chk("rst_ws", word_t'(words_sent), word_t'(0));
    chk("rst_busy", word_t'(busy), word_t'(0));
    chk("rst_ready", word_t'(bus.s_ready), word_t'(1));
    rst = 1'b0;

    // single word
    tick(2);
    push(128'h00112233445566778899aabbccddeeff);
    chk("t1_count1", word_t'(count), word_t'(1));
    tick(1);
    chk("t1_en", word_t'(bus.en_tx), word_t'(1));
    chk("t1_data", bus.data_in,
        128'h00112233445566778899aabbccddeeff);
    chk("t1_count0", word_t'(count), word_t'(0));
    tick(30);
    bus.u_tx_done = 1'b1;
    tick(1);
    bus.u_tx_done = 1'b0;
    chk("t1_en_off", word_t'(bus.en_tx), word_t'(0));
    chk("t1_ws", word_t'(words_sent), word_t'(1));
    tick(8);

    // fill to full, then a blocked sixth word
    launched.delete();
    for (int i = 1; i <= 5; i++) push(word_t'(i));
    chk("fill_count", word_t'(count), word_t'(4));
    chk("fill_ready", word_t'(bus.s_ready), word_t'(0));
    chk("fill_data", bus.data_in, word_t'(1));
    bus.s_valid = 1'b1;
    bus.s_data  = word_t'(6);
    tick(3);
    chk("fill_block", word_t'(count), word_t'(4));
    fork
      push(word_t'(6));
      begin
        bus.u_tx_done = 1'b1;
        tick(1);
        bus.u_tx_done = 1'b0;
      end
    join
    repeat (5) serve(1);
    tick(8);
    chk("fill_n", word_t'(launched.size()), word_t'(6));
    for (int i = 0; i < 6; i++)
      chk("fill_order", launched[i], word_t'(i + 1));

    // gap after a 3-cycle done
    push(word_t'('hA));
    push(word_t'('hB));
    tick(2);
    bus.u_tx_done = 1'b1;
    tick(3);
    bus.u_tx_done = 1'b0;
    for (int k = 0; k < GAP_CYC + 1; k++) begin
      tick(1);
      chk("gap_low", word_t'(bus.en_tx), word_t'(0));
    end
    tick(1);
    chk("gap_rise", word_t'(bus.en_tx), word_t'(1));
    chk("gap_data", bus.data_in, word_t'('hB));
    serve(1);
    tick(8);

    // spurious done while idle and empty
    chk("sp_ws_pre", word_t'(words_sent), word_t'(9));
    bus.u_tx_done = 1'b1;
    tick(2);
    bus.u_tx_done = 1'b0;
    tick(1);
    chk("sp_ws", word_t'(words_sent), word_t'(9));
    chk("sp_busy", word_t'(busy), word_t'(0));
    chk("sp_en", word_t'(bus.en_tx), word_t'(0));
    chk("sp_data", bus.data_in, word_t'('hB));

    // pointer wrap with streaming push/pop
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    launched.delete();
    fork
      for (int i = 0; i < 10; i++)
        push(word_t'(32'h100 + i));
      repeat (10) serve(1);
    join
    tick(8);
    chk("wrap_ws", word_t'(words_sent), word_t'(10));
    chk("wrap_n", word_t'(launched.size()), word_t'(10));
    for (int i = 0; i < 10; i++)
      chk("wrap_order", launched[i], word_t'(32'h100 + i));

    // reset in the middle of a transfer
    push(word_t'('hC1));
    push(word_t'('hC2));
    push(word_t'('hC3));
    chk("mr_count", word_t'(count), word_t'(2));
    chk("mr_en", word_t'(bus.en_tx), word_t'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mr_en_off", word_t'(bus.en_tx), word_t'(0));
    chk("mr_count0", word_t'(count), word_t'(0));
    chk("mr_ws", word_t'(words_sent), word_t'(0));
    chk("mr_ready", word_t'(bus.s_ready), word_t'(1));
    chk("mr_busy", word_t'(busy), word_t'(0));
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
